// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side controller for the synchronous FIFO (registered read port).
// A start command drains exactly burst_len words from the FIFO and presents
// them on a valid/ready stream.  A 3-entry skid buffer absorbs the FIFO's
// one-cycle read latency so the block sustains one word per cycle.
//
// Optional feature macro: FIFO_BURST_READER_LAST_EN
//   When defined, an m_last output flags the final word of each burst, and
//   the skid buffer carries a last tag per entry.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       1-cycle burst command, honoured only while idle
//   burst_len   number of words to drain, sampled with start
//   busy        high whenever the controller is not idle
//   done        1-cycle pulse once the whole burst has left the stream port
//   fifo_rden   FIFO read enable (from registered state only)
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rden
//   fifo_empty  FIFO empty flag
//   m_valid     stream word available
//   m_ready     downstream accepts the word
//   m_data      stream data
//   m_last      (optional) final word of the burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LEN_W-1:0]      burst_len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rden,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_BURST_READER_LAST_EN
   ,
   output logic                  m_last
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   // Advance a skid-buffer pointer, wrapping 2 -> 0.
   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      logic [1:0] n;
      if (p == 2'd2) begin
         n = 2'd0;
      end else begin
         n = p + 2'd1;
      end
      return n;
   endfunction

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [LEN_W-1:0]        len_r;
   logic [LEN_W-1:0]        issued_r;
   logic [LEN_W-1:0]        sent_r;
   logic                    inflight_r;
   logic [1:0]              occ_r;
   logic [1:0]              wr_ptr_r;
   logic [1:0]              rd_ptr_r;
   logic [DATA_WIDTH-1:0]   mem_r [3];
   logic                    fifo_rden_s;
   logic                    push_s;
   logic                    pop_s;
   logic                    accept_start_s;
   logic [LEN_W-1:0]        issued_inc_s;
   logic [2:0]              outstanding_s;
`ifdef FIFO_BURST_READER_LAST_EN
   logic                    last_r [3];
   logic                    last_tag_s;
`endif

   assign issued_inc_s   = issued_r + LEN_ONE;
   // Words held in the buffer plus the one possibly on its way from the FIFO.
   assign outstanding_s  = {1'b0, occ_r} + {2'b00, inflight_r};
   assign push_s         = inflight_r;
   assign pop_s          = m_valid & m_ready;
   assign accept_start_s = (state_r == ST_IDLE) & start;

   assign busy      = (state_r != ST_IDLE);
   assign done      = (state_r == ST_DONE);
   assign fifo_rden = fifo_rden_s;
   assign m_valid   = (occ_r != 2'd0);
   assign m_data    = mem_r[rd_ptr_r];
`ifdef FIFO_BURST_READER_LAST_EN
   // The stale tag of an already-popped entry must not leak out, so gate it.
   assign m_last     = m_valid & last_r[rd_ptr_r];
   // The word arriving now was read when issued_r was one lower.
   assign last_tag_s = (issued_r == len_r);
`endif

   // Read issue decision: registered state and the FIFO flag only, never m_ready.
   always_comb begin
      fifo_rden_s = 1'b0;
      if ((state_r == ST_RUN) && !fifo_empty && (issued_r < len_r) &&
          (outstanding_s < 3'd3)) begin
         fifo_rden_s = 1'b1;
      end else begin
         fifo_rden_s = 1'b0;
      end
   end

   // Next-state logic of the burst controller.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (burst_len == LEN_ZERO) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Leave as soon as the final read has issued (or already had).
            if ((issued_r == len_r) || (fifo_rden_s && (issued_inc_s == len_r))) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!inflight_r && (occ_r == 2'd0) && (sent_r == len_r)) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Burst length latch and issued/sent word counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r    <= LEN_ZERO;
         issued_r <= LEN_ZERO;
         sent_r   <= LEN_ZERO;
      end else if (accept_start_s) begin
         len_r    <= burst_len;
         issued_r <= LEN_ZERO;
         sent_r   <= LEN_ZERO;
      end else begin
         if (fifo_rden_s) begin
            issued_r <= issued_inc_s;
         end
         if (pop_s) begin
            sent_r <= sent_r + LEN_ONE;
         end
      end
   end

   // In-flight flag: a read issued this cycle returns data next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= fifo_rden_s;
      end
   end

   // Skid buffer occupancy and circular pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_r    <= 2'd0;
         wr_ptr_r <= 2'd0;
         rd_ptr_r <= 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
      end
   end

   // Skid buffer storage: capture the FIFO word the cycle after its read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= fifo_rdata;
      end
   end

`ifdef FIFO_BURST_READER_LAST_EN
   // Last-word tag storage, parallel to the data entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            last_r[i] <= 1'b0;
         end
      end else if (push_s) begin
         last_r[wr_ptr_r] <= last_tag_s;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Self-checking bench for fifo_burst_reader.  A behavioural FIFO with a
// registered read port feeds the DUT.  The reference rule is simple: the
// k-th word accepted on the stream must be the k-th word the FIFO held when
// the burst began, exactly burst_len words arrive, done pulses once.
// Directed bursts come from a vector table; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] burst_len;
   logic       busy;
   logic       done;
   logic       fifo_rden;
   logic [7:0] fifo_rdata;
   logic       fifo_empty;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
`ifdef FIFO_BURST_READER_LAST_EN
   logic       m_last;
`endif

   fifo_burst_reader #(.DATA_WIDTH(8), .LEN_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .burst_len  (burst_len),
      .busy       (busy),
      .done       (done),
      .fifo_rden  (fifo_rden),
      .fifo_rdata (fifo_rdata),
      .fifo_empty (fifo_empty),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FIFO_BURST_READER_LAST_EN
      ,
      .m_last     (m_last)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural FIFO (registered read) ----------------
   logic [7:0] fifo_mem [0:4095];
   int         wr_idx;
   int         rd_idx;
   bit         flush_req;

   assign fifo_empty = (rd_idx == wr_idx);

   always @(posedge clk) begin
      if (flush_req) begin
         rd_idx <= wr_idx;
      end else if (fifo_rden && (rd_idx != wr_idx)) begin
         fifo_rdata <= fifo_mem[rd_idx];
         rd_idx     <= rd_idx + 1;
      end
   end

   // ---------------- bookkeeping ----------------
   int checks;
   int errors;
   int cyc;
   bit mon_en;
   int cur_len, burst_base, start_cyc;
   int acc_cnt, rden_cnt, done_cnt, busy_cnt;
   int first_rden, first_valid, first_done;
   int rden_run, rden_run_max, valid_run, valid_run_max;
   bit prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;

   typedef struct {
      int         len;
      int         preload;
      int         late_delay;
      int         rmode;        // 0 always ready, 1 pattern 1,0,0,1,0,1, 2 random
      logic [7:0] base;
      int         restart_at;   // 0 none, else cycle of an extra start while busy
      int         exp_rden_run; // 0 = not checked
      int         exp_valid_run;// 0 = not checked
      int         exp_lat;      // first m_valid minus first fifo_rden, -1 = n/a
      int         exp_busy;     // busy cycles, 0 = not checked
   } vec_t;

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic fifo_write(input logic [7:0] d);
      fifo_mem[wr_idx] = d;
      wr_idx = wr_idx + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle stream monitor, sampling at the falling edge.
   task automatic mon_loop();
      int  outstanding;
      logic [7:0] exp_d;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (fifo_rden) begin
               check_eq("rden_while_empty", int'(fifo_empty), 0);
               rden_cnt++;
               if (first_rden < 0) first_rden = cyc;
               rden_run++;
               if (rden_run > rden_run_max) rden_run_max = rden_run;
            end else begin
               rden_run = 0;
            end
            if (m_valid) begin
               if (first_valid < 0) first_valid = cyc;
               valid_run++;
               if (valid_run > valid_run_max) valid_run_max = valid_run;
            end else begin
               valid_run = 0;
            end
            if (prev_stall) begin
               check_eq("valid_held", int'(m_valid), 1);
               check_eq("data_held", int'(m_data), int'(prev_data));
`ifdef FIFO_BURST_READER_LAST_EN
               check_eq("last_held", int'(m_last), int'(prev_last));
`endif
            end
            outstanding = (rd_idx - burst_base) + int'(fifo_rden) - acc_cnt;
            check_eq("outstanding_le3", int'(outstanding <= 3), 1);
            if (m_valid && m_ready) begin
               if (acc_cnt < cur_len) begin
                  exp_d = fifo_mem[burst_base + acc_cnt];
                  check_eq("stream_data", int'(m_data), int'(exp_d));
`ifdef FIFO_BURST_READER_LAST_EN
                  check_eq("m_last", int'(m_last), int'(acc_cnt == cur_len - 1));
`endif
               end else begin
                  check_eq("extra_word", acc_cnt, cur_len - 1);
               end
               acc_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
`ifdef FIFO_BURST_READER_LAST_EN
            prev_last  = m_last;
`endif
            if (done) begin
               done_cnt++;
               if (first_done < 0) first_done = cyc;
            end
            if (busy) busy_cnt++;
         end
         cyc++;
      end
   endtask

   function automatic logic pick_ready(input int mode, input int k);
      logic [5:0] pat;
      pat = 6'b101001; // bit k%6: 1,0,0,1,0,1
      if (mode == 0) return 1'b1;
      else if (mode == 1) return pat[k % 6];
      else return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic run_burst(input string tag, input vec_t v);
      int bound;
      int post;
      bit finished;
      for (int i = 0; i < v.preload; i++) fifo_write(v.base + 8'(i));
      tick();
      burst_base = rd_idx;
      cur_len = v.len;
      acc_cnt = 0; rden_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_rden = -1; first_valid = -1; first_done = -1;
      rden_run = 0; rden_run_max = 0; valid_run = 0; valid_run_max = 0;
      prev_stall = 1'b0;
      mon_en = 1'b1;
      start = 1'b1;
      burst_len = 8'(v.len);
      m_ready = pick_ready(v.rmode, 0);
      start_cyc = cyc;
      bound = 20 * v.len + 60;
      post = 0;
      finished = 1'b0;
      for (int k = 1; k < bound && !finished; k++) begin
         tick();
         start = (k == v.restart_at);
         if (k == v.restart_at) burst_len = 8'd3;
         m_ready = pick_ready(v.rmode, k);
         if (v.rmode == 0 && v.preload < v.len && v.late_delay >= v.preload + 4 &&
             k == v.late_delay - 1) begin
            check_eq({tag, "_starve_busy"}, int'(busy), 1);
            check_eq({tag, "_starve_rden"}, int'(fifo_rden), 0);
            check_eq({tag, "_starve_reads"}, rden_cnt, v.preload);
         end
         if (k == v.late_delay) begin
            for (int i = v.preload; i < v.len; i++) fifo_write(v.base + 8'(i));
         end
         if (done_cnt > 0) post++;
         if (post >= 3) finished = 1'b1;
      end
      mon_en = 1'b0;
      start = 1'b0;
      m_ready = 1'b0;
      check_eq({tag, "_done_count"}, done_cnt, 1);
      check_eq({tag, "_words"}, acc_cnt, v.len);
      check_eq({tag, "_reads"}, rden_cnt, v.len);
      check_eq({tag, "_fifo_empty"}, int'(fifo_empty), 1);
      check_eq({tag, "_idle_after"}, int'(busy), 0);
      if (v.exp_rden_run > 0) check_eq({tag, "_rden_run"}, rden_run_max, v.exp_rden_run);
      if (v.exp_valid_run > 0) check_eq({tag, "_valid_run"}, valid_run_max, v.exp_valid_run);
      if (v.exp_lat >= 0) check_eq({tag, "_first_valid_lat"}, first_valid - first_rden, v.exp_lat);
      if (v.exp_busy > 0) begin
         check_eq({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
         check_eq({tag, "_done_lat"}, first_done - start_cyc, 1);
      end
   endtask

   vec_t vecs [6];

   initial begin
      vec_t rv;
      int   rden_seen;
      checks = 0; errors = 0; cyc = 0;
      wr_idx = 0; rd_idx = 0; flush_req = 1'b0; mon_en = 1'b0;
      rst = 1'b1; start = 1'b0; burst_len = 8'd0; m_ready = 1'b0;
      cur_len = 0; burst_base = 0;
      fork
         mon_loop();
      join_none

      //                len pre late rm base   rst rdn vld lat busy
      vecs[0] = '{len:8,   preload:8,   late_delay:0,  rmode:0, base:8'h11, restart_at:0,
                  exp_rden_run:8, exp_valid_run:8, exp_lat:2,  exp_busy:0};
      vecs[1] = '{len:5,   preload:5,   late_delay:0,  rmode:1, base:8'hA0, restart_at:0,
                  exp_rden_run:0, exp_valid_run:0, exp_lat:2,  exp_busy:0};
      vecs[2] = '{len:4,   preload:2,   late_delay:10, rmode:0, base:8'h30, restart_at:0,
                  exp_rden_run:2, exp_valid_run:0, exp_lat:2,  exp_busy:0};
      vecs[3] = '{len:0,   preload:0,   late_delay:0,  rmode:0, base:8'h00, restart_at:0,
                  exp_rden_run:0, exp_valid_run:0, exp_lat:-1, exp_busy:1};
      vecs[4] = '{len:8,   preload:8,   late_delay:0,  rmode:0, base:8'h50, restart_at:3,
                  exp_rden_run:8, exp_valid_run:8, exp_lat:2,  exp_busy:0};
      vecs[5] = '{len:255, preload:255, late_delay:0,  rmode:2, base:8'h07, restart_at:0,
                  exp_rden_run:0, exp_valid_run:0, exp_lat:2,  exp_busy:0};

      // ---- reset state ----
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_rden", int'(fifo_rden), 0);
      check_eq("rst_valid", int'(m_valid), 0);
      check_eq("rst_data", int'(m_data), 0);

      // ---- async reset mid-burst with 4 words in the FIFO ----
      for (int i = 0; i < 4; i++) fifo_write(8'hC1 + 8'(i));
      start = 1'b1; burst_len = 8'd4;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_eq("pre_rst_valid", int'(m_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_busy", int'(busy), 0);
      check_eq("async_done", int'(done), 0);
      check_eq("async_rden", int'(fifo_rden), 0);
      check_eq("async_valid", int'(m_valid), 0);
      check_eq("async_data", int'(m_data), 0);
      repeat (2) tick();
      rst = 1'b0;
      m_ready = 1'b1;
      rden_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (fifo_rden) rden_seen++;
      end
      check_eq("post_rst_no_rden", rden_seen, 0);
      check_eq("post_rst_idle", int'(busy), 0);
      m_ready = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();

      // ---- directed table ----
      foreach (vecs[i]) begin
         run_burst($sformatf("vec%0d", i), vecs[i]);
      end

      // ---- randomized bursts ----
      for (int n = 0; n < 25; n++) begin
         rv.len           = $urandom_range(0, 24);
         rv.preload       = $urandom_range(0, rv.len);
         rv.late_delay    = $urandom_range(1, 15);
         rv.rmode         = 2;
         rv.base          = 8'($urandom_range(0, 255));
         rv.restart_at    = (rv.len >= 8) ? $urandom_range(0, 3) : 0;
         rv.exp_rden_run  = 0;
         rv.exp_valid_run = 0;
         rv.exp_lat       = (rv.len == 0) ? -1 : 2;
         rv.exp_busy      = (rv.len == 0) ? 1 : 0;
         run_burst($sformatf("rnd%0d", n), rv);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
